timer_counter_param: RTL

Parametrised successor to the single-digit time counter. It counts enabled clock steps up or down between 0 and a configurable terminal value, in periodic (wrap) or one-shot (expire-and-hold) mode. It supports synchronous clear and preload, emits a registered one-cycle terminal pulse, and provides a combinational carry for cascading digit counters (units -> tens -> minutes) in the timing datapath.

---
 rtl/timer_counter_param_pkg.sv | 22 ++
 rtl/timer_counter_param.sv | 85 ++++++++
 2 files changed

// File: rtl/timer_counter_param_pkg.sv
// Shared encodings and parameter legality check for the cascadable digit timer.
// Pure declarations: no latency, no flow control.
package timer_counter_param_pkg;

    typedef enum logic {
        ARMED   = 1'b0,
        EXPIRED = 1'b1
    } tcp_state_e;

    localparam logic DIR_UP        = 1'b0;
    localparam logic DIR_DN        = 1'b1;
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // MAX_COUNT must be reachable in WIDTH bits and leave a non-empty period.
    function automatic bit tcp_params_legal(input int unsigned w, input int unsigned m);
        longint unsigned limit;
        limit = (longint'(1) << w) - 1;
        return (w >= 1) && (w <= 31) && (m >= 1) && (longint'(m) <= limit);
    endfunction

endpackage

// File: rtl/timer_counter_param.sv
// Up/down digit counter, periodic or one-shot; tempo/end_time/done registered (1 cycle), carry combinational.
// No backpressure: E is the only throttle, and carry feeds E of the next cascaded stage.
module timer_counter_param
    import timer_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 9
) (
    input  logic             clkt,
    input  logic             R,
    input  logic             E,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] tempo,
    output logic             end_time,
    output logic             done,
    output logic             carry
);

    generate
        if (!tcp_params_legal(WIDTH, MAX_COUNT)) begin : g_bad_params
            $error("timer_counter_param: MAX_COUNT must satisfy 1 <= MAX_COUNT <= 2^WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] tempo_q, tempo_d;
    logic             end_q, end_d;
    tcp_state_e       state_q, state_d;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] reload;
    logic             at_terminal;

    assign terminal    = (dir == DIR_DN) ? '0 : MAXV;
    assign reload      = (dir == DIR_DN) ? MAXV : '0;
    assign at_terminal = (tempo_q == terminal);

    always_comb begin
        tempo_d = tempo_q;
        state_d = state_q;
        end_d   = 1'b0;
        if (clr) begin
            tempo_d = reload;
            state_d = ARMED;
        end else if (load) begin
            tempo_d = (load_val > MAXV) ? MAXV : load_val;
            state_d = ARMED;
        end else if (E && (state_q == ARMED)) begin
            if (!at_terminal) begin
                tempo_d = (dir == DIR_DN) ? (tempo_q - ONE) : (tempo_q + ONE);
            end else begin
                end_d = 1'b1;
                // One-shot parks on the terminal value instead of reloading.
                if (mode == MODE_ONESHOT) begin
                    state_d = EXPIRED;
                end else begin
                    tempo_d = reload;
                end
            end
        end
    end

    always_ff @(posedge clkt or posedge R) begin
        if (R) begin
            tempo_q <= '0;
            end_q   <= 1'b0;
            state_q <= ARMED;
        end else begin
            tempo_q <= tempo_d;
            end_q   <= end_d;
            state_q <= state_d;
        end
    end

    assign tempo    = tempo_q;
    assign end_time = end_q;
    assign done     = (state_q == EXPIRED);
    assign carry    = E && (state_q == ARMED) && at_terminal;

endmodule
